rule_cfg_master: RTL and testbench
==================================

Name: rule_cfg_master

Overview:
- Configuration master that drives the rule-write/read port (rule_wren/rden/addr/wdata/rdata_valid/rdata) of Parser_Top / Deparser_Top.
- Accepts host commands on a valid/ready stream, checks the address map, and issues single-cycle write or read strobes.
- Waits for read data with a timeout and returns one response per command.
- Sits between the host/CSR bridge and one parser or deparser instance; replaces testbench force/poke configuration.

Parameters:
- RD_TIMEOUT, 64, cycles to wait for i_rule_rdata_valid after a read strobe before flagging an error (min 2).
- ADDR_SEL_MAX, 5, highest legal value of addr[10:8].
- CNT_WIDTH, 16, width of the saturating statistics counters.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  command ready
- i_cmd_wr  in  1  1 = write, 0 = read
- i_cmd_addr  in  32  rule address ([10:8] = selector, low bits = offset)
- i_cmd_wdata  in  32  write data
- o_resp_valid  out  1  response valid
- i_resp_ready  in  1  response ready
- o_resp_rdata  out  32  read data (0 for writes and errors)
- o_resp_err  out  1  1 = illegal address or read timeout
- o_rule_wren  out  1  rule write strobe
- o_rule_rden  out  1  rule read strobe
- o_rule_addr  out  32  rule address
- o_rule_wdata  out  32  rule write data
- i_rule_rdata_valid  in  1  read data valid from the slave
- i_rule_rdata  in  32  read data from the slave
- o_cmd_cnt  out  CNT_WIDTH  number of commands accepted (saturating)
- o_err_cnt  out  CNT_WIDTH  number of error responses issued (saturating)

Behaviour:
Reset (async assert, sync release):
- State is IDLE.
- All outputs are 0, except o_cmd_ready, which is 1 in the first cycle after release.
- Reset mid-operation abandons the in-flight command: no strobe and no response.

FSM states: IDLE, ISSUE_WR, ISSUE_RD, RD_WAIT, RESP.
- IDLE: o_cmd_ready = 1. A handshake (valid & ready) latches wr/addr/wdata and increments o_cmd_cnt.
  - If addr[10:8] > ADDR_SEL_MAX: go to RESP with err = 1 and rdata = 0. No rule strobe is issued.
  - Else: go to ISSUE_WR or ISSUE_RD.
- ISSUE_WR: o_rule_wren = 1 for exactly 1 cycle with the latched addr/wdata, then RESP with err = 0, rdata = 0.
- ISSUE_RD: o_rule_rden = 1 for exactly 1 cycle with the latched addr. Clear the timeout counter, then RD_WAIT.
- RD_WAIT: the counter increments each cycle.
  - On i_rule_rdata_valid: capture i_rule_rdata, go to RESP with err = 0.
  - When the counter reaches RD_TIMEOUT-1 with no valid: go to RESP with err = 1, rdata = 0.
  - If valid and the timeout coincide in the same cycle, valid wins (err = 0).
- RESP: o_resp_valid is held with stable rdata/err until i_resp_ready. On the handshake go to IDLE; o_cmd_ready returns 1 the following cycle.

General rules:
- o_cmd_ready = 0 in every state except IDLE. There is no command pipelining, so at most one command is outstanding.
- o_rule_addr and o_rule_wdata are 0 whenever no strobe is asserted. This gives a clean waveform; the slave must not depend on it.
- i_rule_rdata_valid outside RD_WAIT is ignored and has no effect.
- Latency (handshake at cycle N):
  - Write: wren at N+1, resp_valid at N+2.
  - Read: rden at N+1; rdata_valid at cycle M (M ≥ N+2) gives resp_valid at M+1.
  - Illegal address: resp_valid at N+1.
- o_err_cnt increments when an err = 1 response is accepted.
- Both counters saturate at all-ones and do not wrap.

Decomposition:
- parser_pkg gains:
  - localparams RULE_SEL_RULE = 0, RULE_SEL_TYPE = 1, RULE_SEL_TYPEOFF = 2, RULE_SEL_KEYOFF = 3, RULE_SEL_HEADSHIFT = 4, RULE_SEL_METASHIFT = 5.
  - a typedef enum for the FSM state.
  - a packed struct rule_cmd_t {wr, addr[31:0], wdata[31:0]}.
- No sub-module. The timeout counter and the statistics counters are inline.

Test Plan:
- Write addr 0x0000_0302, wdata 0x0001_0506 → one wren cycle at N+1 with that addr/data; resp err = 0, rdata = 0 at N+2; o_cmd_cnt = 1.
- Read addr 0x0000_0200; slave returns rdata_valid with 0x0000_000C three cycles after rden → resp rdata = 0x0000_000C, err = 0, one cycle after rdata_valid.
- Read with the slave silent, RD_TIMEOUT = 64 → resp err = 1, rdata = 0 exactly 64 cycles after the rden cycle; o_err_cnt = 1.
- Command addr 0x0000_0700 (selector 7) → no wren or rden ever asserted; resp err = 1 at N+1.
- Hold i_resp_ready = 0 for 10 cycles → resp_valid/rdata stay stable and cmd_ready stays 0; back-to-back commands are all serviced in order.
- Assert i_rst_n = 0 during RD_WAIT, then return the late rdata_valid after release → no response emitted, state IDLE, all counters 0.

Source files
------------

// File: rtl/rule_cfg_master_pkg.sv
// Shared types and constants for the rule configuration master.
`default_nettype none

package rule_cfg_master_pkg;

  // Selector values carried in rule address bits [10:8]
  localparam int RULE_SEL_RULE      = 0;
  localparam int RULE_SEL_TYPE      = 1;
  localparam int RULE_SEL_TYPEOFF   = 2;
  localparam int RULE_SEL_KEYOFF    = 3;
  localparam int RULE_SEL_HEADSHIFT = 4;
  localparam int RULE_SEL_METASHIFT = 5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE_WR = 3'd1,
    ST_ISSUE_RD = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RESP     = 3'd4
  } state_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } rule_cmd_t;

  function automatic logic sel_legal(input logic [2:0] sel, input int sel_max);
    return int'(sel) <= sel_max;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rule_cfg_master_if.sv
// Host command/response stream plus rule port of the configuration master.
`default_nettype none

interface rule_cfg_master_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 i_cmd_valid;
  logic                 o_cmd_ready;
  logic                 i_cmd_wr;
  logic [31:0]          i_cmd_addr;
  logic [31:0]          i_cmd_wdata;
  logic                 o_resp_valid;
  logic                 i_resp_ready;
  logic [31:0]          o_resp_rdata;
  logic                 o_resp_err;
  logic                 o_rule_wren;
  logic                 o_rule_rden;
  logic [31:0]          o_rule_addr;
  logic [31:0]          o_rule_wdata;
  logic                 i_rule_rdata_valid;
  logic [31:0]          i_rule_rdata;
  logic [CNT_WIDTH-1:0] o_cmd_cnt;
  logic [CNT_WIDTH-1:0] o_err_cnt;

  modport master (
    input  i_cmd_valid, i_cmd_wr, i_cmd_addr, i_cmd_wdata, i_resp_ready,
           i_rule_rdata_valid, i_rule_rdata,
    output o_cmd_ready, o_resp_valid, o_resp_rdata, o_resp_err,
           o_rule_wren, o_rule_rden, o_rule_addr, o_rule_wdata,
           o_cmd_cnt, o_err_cnt
  );

  modport slave (
    output i_cmd_valid, i_cmd_wr, i_cmd_addr, i_cmd_wdata, i_resp_ready,
           i_rule_rdata_valid, i_rule_rdata,
    input  o_cmd_ready, o_resp_valid, o_resp_rdata, o_resp_err,
           o_rule_wren, o_rule_rden, o_rule_addr, o_rule_wdata,
           o_cmd_cnt, o_err_cnt
  );

endinterface

`default_nettype wire

// File: rtl/rule_cfg_master.sv
// Turns host commands into single-cycle rule write/read strobes and returns
// one response per command, with address checking and a read timeout.
`default_nettype none

module rule_cfg_master
  import rule_cfg_master_pkg::*;
#(
  parameter int RD_TIMEOUT   = 64,
  parameter int ADDR_SEL_MAX = 5,
  parameter int CNT_WIDTH    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  rule_cfg_master_if.master bus
);

  localparam int                   TO_W    = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;
  // Leaving RD_WAIT at this count puts the error response RD_TIMEOUT cycles after rden
  localparam logic [TO_W-1:0]      TO_LAST = TO_W'(RD_TIMEOUT - 2);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  rule_cmd_t cmd_in;
  assign cmd_in = '{wr: bus.i_cmd_wr, addr: bus.i_cmd_addr, wdata: bus.i_cmd_wdata};

  state_t               state_q;
  logic                 cmd_ready_q;
  logic                 resp_valid_q;
  logic                 resp_err_q;
  logic [31:0]          resp_rdata_q;
  logic                 rule_wren_q;
  logic                 rule_rden_q;
  logic [31:0]          rule_addr_q;
  logic [31:0]          rule_wdata_q;
  logic [TO_W-1:0]      to_cnt_q;
  logic [CNT_WIDTH-1:0] cmd_cnt_q;
  logic [CNT_WIDTH-1:0] err_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      cmd_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      rule_wren_q  <= 1'b0;
      rule_rden_q  <= 1'b0;
      rule_addr_q  <= '0;
      rule_wdata_q <= '0;
      to_cnt_q     <= '0;
      cmd_cnt_q    <= '0;
      err_cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.i_cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            if (cmd_cnt_q != CNT_MAX) cmd_cnt_q <= cmd_cnt_q + 1'b1;
            if (!sel_legal(cmd_in.addr[10:8], ADDR_SEL_MAX)) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
              state_q      <= ST_RESP;
            end else if (cmd_in.wr) begin
              rule_wren_q  <= 1'b1;
              rule_addr_q  <= cmd_in.addr;
              rule_wdata_q <= cmd_in.wdata;
              state_q      <= ST_ISSUE_WR;
            end else begin
              rule_rden_q  <= 1'b1;
              rule_addr_q  <= cmd_in.addr;
              state_q      <= ST_ISSUE_RD;
            end
          end
        end
        ST_ISSUE_WR: begin
          rule_wren_q  <= 1'b0;
          rule_addr_q  <= '0;
          rule_wdata_q <= '0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
          state_q      <= ST_RESP;
        end
        ST_ISSUE_RD: begin
          rule_rden_q <= 1'b0;
          rule_addr_q <= '0;
          to_cnt_q    <= '0;
          state_q     <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          // Data arriving on the final wait cycle still beats the timeout
          if (bus.i_rule_rdata_valid) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= bus.i_rule_rdata;
            state_q      <= ST_RESP;
          end else if (to_cnt_q == TO_LAST) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
            state_q      <= ST_RESP;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.i_resp_ready) begin
            if (resp_err_q && (err_cnt_q != CNT_MAX)) err_cnt_q <= err_cnt_q + 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            cmd_ready_q  <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          cmd_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_cmd_ready  = cmd_ready_q;
  assign bus.o_resp_valid = resp_valid_q;
  assign bus.o_resp_err   = resp_err_q;
  assign bus.o_resp_rdata = resp_rdata_q;
  assign bus.o_rule_wren  = rule_wren_q;
  assign bus.o_rule_rden  = rule_rden_q;
  assign bus.o_rule_addr  = rule_addr_q;
  assign bus.o_rule_wdata = rule_wdata_q;
  assign bus.o_cmd_cnt    = cmd_cnt_q;
  assign bus.o_err_cnt    = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_rule_cfg_master.sv
// Scoreboard bench for rule_cfg_master: random commands, a reactive rule slave,
// and a command-level reference model of responses, strobes and counters.
`default_nettype none

module tb_rule_cfg_master;

  localparam int RD_TO   = 64;
  localparam int SEL_MAX = 5;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rule_cfg_master_if #(.CNT_WIDTH(CW)) bif();

  rule_cfg_master #(
    .RD_TIMEOUT  (RD_TO),
    .ADDR_SEL_MAX(SEL_MAX),
    .CNT_WIDTH   (CW)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bif)
  );

  typedef struct {logic err; logic [31:0] rdata; int cyc;} resp_t;
  typedef struct {logic wr; logic [31:0] addr; logic [31:0] wdata; int cyc;} strb_t;
  // d = cycles from the rden cycle to the slave's rdata_valid
  typedef struct {int d; logic [31:0] data;} plan_t;

  resp_t rq[$];
  strb_t sq[$];
  plan_t pq[$];

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int exp_cmd = 0;
  int exp_err = 0;
  int hold_until = 0;
  bit in_resp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h expected none (cycle %0d)", name, act, cyc);
  endtask

  function automatic int sat(input int n);
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  // Reference model: everything about a command is decided at its handshake
  task automatic model(input int n, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input plan_t pl);
    int sel;
    sel = int'(addr[10:8]);
    exp_cmd++;
    if (sel > SEL_MAX) begin
      rq.push_back('{1'b1, 32'd0, n + 1});
    end else if (wr) begin
      sq.push_back('{1'b1, addr, wdata, n + 1});
      rq.push_back('{1'b0, 32'd0, n + 2});
    end else begin
      sq.push_back('{1'b0, addr, 32'd0, n + 1});
      pq.push_back(pl);
      if (pl.d >= RD_TO) rq.push_back('{1'b1, 32'd0, n + 1 + RD_TO});
      else               rq.push_back('{1'b0, pl.data, n + 2 + pl.d});
    end
  endtask

  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input plan_t pl);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk); #1;
      bif.i_cmd_valid = 1'b1;
      bif.i_cmd_wr    = wr;
      bif.i_cmd_addr  = addr;
      bif.i_cmd_wdata = wdata;
      if (bif.o_cmd_ready === 1'b1) begin
        done = 1'b1;
        model(cyc, wr, addr, wdata, pl);
      end
    end
    if (!done) begin
      fail("cmd_accept_timeout", addr);
      bif.i_cmd_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      bif.i_cmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk); #1;
      bif.i_cmd_valid = 1'b0;
      if (rq.size() == 0 && sq.size() == 0 && !in_resp) done = 1'b1;
    end
    if (!done) fail("drain_timeout", 32'(rq.size()));
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_cmd_cnt"}, 32'(bif.o_cmd_cnt), 32'(sat(exp_cmd)));
    chk({tag, "_err_cnt"}, 32'(bif.o_err_cnt), 32'(sat(exp_err)));
  endtask

  // Response acceptance from the host side
  initial begin
    bif.i_resp_ready = 1'b0;
    forever begin
      @(negedge clk); #1;
      bif.i_resp_ready = (cyc < hold_until) ? 1'b0 : (($urandom % 4) != 0);
    end
  end

  // Rule slave: answers each read strobe according to the queued plan
  initial begin
    int due;
    plan_t p;
    due = -1;
    p = '{0, 32'd0};
    bif.i_rule_rdata_valid = 1'b0;
    bif.i_rule_rdata       = 32'd0;
    forever begin
      @(negedge clk); #1;
      if (bif.o_rule_rden === 1'b1 && pq.size() != 0) begin
        p   = pq.pop_front();
        due = cyc + p.d;
      end
      if (cyc == due) begin
        bif.i_rule_rdata_valid = 1'b1;
        bif.i_rule_rdata       = p.data;
      end else begin
        bif.i_rule_rdata_valid = 1'b0;
        bif.i_rule_rdata       = $urandom;
      end
    end
  end

  // Monitor: strobes and responses against the scoreboard queues
  initial begin
    resp_t cur;
    strb_t e;
    logic [31:0] held_rdata;
    logic        held_err;
    cur = '{1'b0, 32'd0, 0};
    held_rdata = 32'd0;
    held_err = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
        in_resp = 1'b0;
      end else begin
        if (bif.o_rule_wren || bif.o_rule_rden) begin
          chk("cmd_ready_during_strobe", 32'(bif.o_cmd_ready), 32'd0);
          if (sq.size() == 0) begin
            fail("unexpected_strobe", bif.o_rule_addr);
          end else begin
            e = sq.pop_front();
            chk("strobe_exclusive", 32'(bif.o_rule_wren & bif.o_rule_rden), 32'd0);
            chk("strobe_kind", 32'(bif.o_rule_wren), 32'(e.wr));
            chk("strobe_addr", bif.o_rule_addr, e.addr);
            if (e.wr) chk("strobe_wdata", bif.o_rule_wdata, e.wdata);
            chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
          end
        end else begin
          chk("idle_rule_addr", bif.o_rule_addr, 32'd0);
          chk("idle_rule_wdata", bif.o_rule_wdata, 32'd0);
        end

        if (bif.o_resp_valid) begin
          chk("cmd_ready_during_resp", 32'(bif.o_cmd_ready), 32'd0);
          if (!in_resp) begin
            in_resp = 1'b1;
            if (rq.size() == 0) begin
              fail("unexpected_resp", bif.o_resp_rdata);
              cur = '{bif.o_resp_err, bif.o_resp_rdata, cyc};
            end else begin
              cur = rq.pop_front();
              chk("resp_err", 32'(bif.o_resp_err), 32'(cur.err));
              chk("resp_rdata", bif.o_resp_rdata, cur.rdata);
              chk("resp_cycle", 32'(cyc), 32'(cur.cyc));
            end
            held_err   = bif.o_resp_err;
            held_rdata = bif.o_resp_rdata;
          end else begin
            chk("resp_stable_rdata", bif.o_resp_rdata, held_rdata);
            chk("resp_stable_err", 32'(bif.o_resp_err), 32'(held_err));
          end
          if (bif.i_resp_ready) begin
            in_resp = 1'b0;
            if (cur.err) exp_err++;
          end
        end else if (in_resp) begin
          fail("resp_dropped", 32'd0);
          in_resp = 1'b0;
        end
      end
    end
  end

  initial begin
    plan_t none;
    logic [31:0] a;
    logic        w;
    int          k;
    plan_t       pl;
    none = '{0, 32'd0};

    bif.i_cmd_valid = 1'b0;
    bif.i_cmd_wr    = 1'b0;
    bif.i_cmd_addr  = 32'd0;
    bif.i_cmd_wdata = 32'd0;
    idle(3);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #2;
    chk("rst_cmd_ready", 32'(bif.o_cmd_ready), 32'd1);
    chk("rst_resp_valid", 32'(bif.o_resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bif.o_resp_err), 32'd0);
    chk("rst_resp_rdata", bif.o_resp_rdata, 32'd0);
    chk("rst_wren", 32'(bif.o_rule_wren), 32'd0);
    chk("rst_rden", 32'(bif.o_rule_rden), 32'd0);
    check_counts("rst");

    // Directed cases
    send(1'b1, 32'h0000_0302, 32'h0001_0506, none);
    drain();
    check_counts("first_write");
    send(1'b0, 32'h0000_0200, 32'd0, '{3, 32'h0000_000C});
    drain();
    send(1'b0, 32'h0000_0300, 32'd0, '{RD_TO, 32'hDEAD_BEEF});
    drain();
    check_counts("timeout");
    send(1'b1, 32'h0000_0700, 32'h1234_5678, none);
    send(1'b0, 32'h0000_0600, 32'd0, none);
    drain();
    send(1'b1, 32'h0000_05FF, 32'hA5A5_5A5A, none);
    send(1'b0, 32'h0000_0104, 32'd0, '{1, 32'h0BAD_F00D});
    send(1'b0, 32'h0000_0408, 32'd0, '{RD_TO - 1, 32'h7777_0001});
    drain();
    check_counts("boundaries");

    hold_until = cyc + 12;
    send(1'b1, 32'h0000_0010, 32'h0000_00AA, none);
    send(1'b0, 32'h0000_0120, 32'd0, '{2, 32'h0000_0055});
    send(1'b1, 32'h0000_0F00, 32'h0, none);
    send(1'b1, 32'h0000_0330, 32'hFFFF_FFFF, none);
    drain();
    check_counts("back_to_back");

    // Random traffic, long enough to saturate both counters
    for (int i = 0; i < 70; i++) begin
      a       = $urandom;
      w       = 1'($urandom % 2);
      k       = int'($urandom % 6);
      pl.data = $urandom;
      case (k)
        0:       pl.d = 1;
        1:       pl.d = RD_TO - 1;
        2:       pl.d = RD_TO + int'($urandom % 2);
        default: pl.d = int'($urandom_range(1, RD_TO - 1));
      endcase
      if (($urandom % 8) == 0) hold_until = cyc + int'($urandom_range(3, 10));
      send(w, a, $urandom, pl);
      if (($urandom % 4) == 0) idle(int'($urandom_range(1, 3)));
    end
    drain();
    check_counts("random");

    // Reset while a read is waiting; the late read data must be ignored
    send(1'b0, 32'h0000_0240, 32'd0, '{30, 32'hCAFE_0001});
    idle(10);
    @(negedge clk); #1;
    rst_n = 1'b0;
    rq.delete();
    sq.delete();
    exp_cmd = 0;
    exp_err = 0;
    idle(3);
    @(negedge clk); #1;
    rst_n = 1'b1;
    idle(40);
    chk("post_rst_cmd_ready", 32'(bif.o_cmd_ready), 32'd1);
    chk("post_rst_resp_valid", 32'(bif.o_resp_valid), 32'd0);
    check_counts("post_rst");

    send(1'b1, 32'h0000_0500, 32'h0000_0001, none);
    drain();
    check_counts("after_rst_write");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire
